tdc_result_readout: RTL

- Downstream stage of the TDC delay-line capture inside the TinyTapeout top.
- Takes the thermometer code latched from the delay line when the stop event occurs.
- Applies bubble correction and converts it to a binary delay count.
- Holds the result with status flags and presents one selected byte on the 8-bit output bus, with a read-acknowledge handshake.

---
 rtl/tdc_pkg.sv | 25 ++
 rtl/tdc_therm2bin.sv | 41 ++++
 rtl/tdc_result_readout.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC result readout path.
package tdc_pkg;

    // Readout FSM: two encode stages, then hold until the consumer acknowledges.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC1 = 2'd1,
        ENC2 = 2'd2,
        FULL = 2'd3
    } tdc_state_e;

    // Byte-select codes for the 8-bit readout bus.
    localparam logic [1:0] SEL_RESULT = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] SEL_RAW    = 2'd3;

    // Bit positions inside the status byte; bits [2:0] read as zero.
    localparam int STAT_RES_VALID = 7;
    localparam int STAT_OVF       = 6;
    localparam int STAT_ZERO      = 5;
    localparam int STAT_LOST      = 4;
    localparam int STAT_BUSY      = 3;

endpackage

// File: rtl/tdc_therm2bin.sv
// Combinational thermometer helpers: 3-tap majority bubble correction of a raw
// code, and popcount/extreme detection of an already corrected code. The two
// halves are independent so the caller can register between them.
module tdc_therm2bin #(
    parameter int N_DELAY = 64,
    parameter int RES_W   = $clog2(N_DELAY + 1)
) (
    input  logic [N_DELAY-1:0] therm_i,
    output logic [N_DELAY-1:0] corr_o,
    input  logic [N_DELAY-1:0] corr_i,
    output logic [RES_W-1:0]   count_o,
    output logic               ovf_o,
    output logic               zero_o
);

    // Pad so the tap before bit 0 reads 1 and the tap after the last reads 0.
    logic [N_DELAY+1:0] therm_pad;
    assign therm_pad = {1'b0, therm_i, 1'b1};

    // Majority of each tap with its two neighbours removes single-bit bubbles.
    always_comb begin
        corr_o = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            corr_o[i] = (therm_pad[i]   & therm_pad[i+1]) |
                        (therm_pad[i]   & therm_pad[i+2]) |
                        (therm_pad[i+1] & therm_pad[i+2]);
        end
    end

    // Popcount of the corrected code; a full line counts to exactly N_DELAY.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            count_o = count_o + RES_W'(corr_i[i]);
        end
    end

    assign ovf_o  = &corr_i;
    assign zero_o = ~|corr_i;

endmodule

// File: rtl/tdc_result_readout.sv
// TDC result readout: captures the latched delay-line code, bubble-corrects it
// (stage 1), converts it to a binary count (stage 2), then holds the result with
// status flags and serves one selected byte per cycle on a registered bus.
module tdc_result_readout
    import tdc_pkg::*;
#(
    parameter int N_DELAY = 64,
    parameter int RES_W   = $clog2(N_DELAY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DELAY-1:0] therm_i,
    input  logic               therm_valid_i,
    input  logic               rd_ack_i,
    input  logic               clr_i,
    input  logic [1:0]         byte_sel_i,
    output logic [7:0]         out_byte_o,
    output logic               res_valid_o,
    output logic               busy_o
);

    // Result is presented zero-extended on the byte bus.
    function automatic logic [7:0] result_byte(input logic [RES_W-1:0] r);
        return 8'(r);
    endfunction

    function automatic logic [7:0] status_byte(input logic vld, input logic ovf,
                                               input logic zero, input logic lost,
                                               input logic busy);
        logic [7:0] s;
        s                 = '0;
        s[STAT_RES_VALID] = vld;
        s[STAT_OVF]       = ovf;
        s[STAT_ZERO]      = zero;
        s[STAT_LOST]      = lost;
        s[STAT_BUSY]      = busy;
        return s;
    endfunction

    tdc_state_e         state_q, state_d;
    logic [N_DELAY-1:0] therm_p0_q, therm_p0_d;
    logic [N_DELAY-1:0] corr_p1_q, corr_p1_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic [7:0]         raw_q, raw_d;
    logic               lost_q, lost_d;
    logic [7:0]         sample_cnt_q, sample_cnt_d;
    logic [7:0]         out_byte_q, out_byte_d;

    logic [N_DELAY-1:0] corr_c;
    logic [RES_W-1:0]   count_c;
    logic               ovf_c;
    logic               zero_c;
    logic [7:0]         raw_c;
    logic               accept;
    logic               drop;

    tdc_therm2bin #(
        .N_DELAY (N_DELAY),
        .RES_W   (RES_W)
    ) u_therm2bin (
        .therm_i (therm_p0_q),
        .corr_o  (corr_c),
        .corr_i  (corr_p1_q),
        .count_o (count_c),
        .ovf_o   (ovf_c),
        .zero_o  (zero_c)
    );

    // Low byte of the corrected code for debug readout; narrow lines pad with zeros.
    generate
        if (N_DELAY >= 8) begin : g_raw_wide
            assign raw_c = corr_p1_q[7:0];
        end else begin : g_raw_narrow
            assign raw_c = 8'(corr_p1_q);
        end
    endgenerate

    assign res_valid_o = (state_q == FULL);
    assign busy_o      = (state_q == ENC1) || (state_q == ENC2);
    assign out_byte_o  = out_byte_q;

    // Next-state, capture/drop decision, pipeline advance and readout mux.
    always_comb begin
        state_d      = state_q;
        therm_p0_d   = therm_p0_q;
        corr_p1_d    = corr_p1_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;
        raw_d        = raw_q;
        lost_d       = lost_q;
        sample_cnt_d = sample_cnt_q;
        out_byte_d   = out_byte_q;

        // A capture lands only when the pipeline is empty or is being emptied now.
        accept = therm_valid_i &&
                 ((state_q == IDLE) || ((state_q == FULL) && rd_ack_i));
        drop   = therm_valid_i && !accept;

        if (accept) begin
            therm_p0_d = therm_i;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = ENC1;
            end
            ENC1: begin
                corr_p1_d = corr_c;
                state_d   = ENC2;
            end
            ENC2: begin
                result_d     = count_c;
                ovf_d        = ovf_c;
                zero_d       = zero_c;
                raw_d        = raw_c;
                sample_cnt_d = sample_cnt_q + 8'd1;
                state_d      = FULL;
            end
            FULL: begin
                if (rd_ack_i) state_d = accept ? ENC1 : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (drop) lost_d = 1'b1;

        // Clear outranks both a same-cycle drop and a same-cycle count increment.
        if (clr_i) begin
            lost_d       = 1'b0;
            sample_cnt_d = '0;
        end

        case (byte_sel_i)
            SEL_RESULT: out_byte_d = result_byte(result_q);
            SEL_STATUS: out_byte_d = status_byte(res_valid_o, ovf_q, zero_q, lost_q, busy_o);
            SEL_COUNT:  out_byte_d = sample_cnt_q;
            SEL_RAW:    out_byte_d = raw_q;
            default:    out_byte_d = '0;
        endcase
    end

    // Control, held result, flags and readout register; reset clears all of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
            raw_q        <= '0;
            lost_q       <= 1'b0;
            sample_cnt_q <= '0;
            out_byte_q   <= '0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            zero_q       <= zero_d;
            raw_q        <= raw_d;
            lost_q       <= lost_d;
            sample_cnt_q <= sample_cnt_d;
            out_byte_q   <= out_byte_d;
        end
    end

    // Stage 0 -> 1 data path; contents are only consumed under FSM control.
    always_ff @(posedge clk) begin
        therm_p0_q <= therm_p0_d;
        corr_p1_q  <= corr_p1_d;
    end

endmodule
